// File: rtl/mem_log_reader.sv
// Logger memory dump engine: walks every address, waits the read latency,
// and streams each I/Q word as two bytes over a valid/ready interface.
module mem_log_reader #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_mem_full,
  input  logic [31:0]                i_data_log_from_mem,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  input  logic                       i_tx_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_HI,
    SEND_LO,
    DONE
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

  state_t                     state;
  state_t                     state_nx;
  logic [3:0]                 lat_cnt;
  logic [3:0]                 lat_cnt_nx;
  logic [15:0]                word;
  logic [15:0]                word_nx;
  logic [BRAM_ADDR_WIDTH-1:0] addr_nx;
  logic [7:0]                 tx_data_nx;
  logic                       err_nx;
  logic                       last;
  logic                       data_unused;

  assign last        = &o_addr_log_to_mem;
  assign data_unused = ^i_data_log_from_mem[31:16];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      lat_cnt           <= '0;
      word              <= '0;
      o_addr_log_to_mem <= '0;
      o_tx_data         <= '0;
      o_tx_valid        <= 1'b0;
      o_read_log        <= 1'b0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= 1'b0;
    end else begin
      state             <= state_nx;
      lat_cnt           <= lat_cnt_nx;
      word              <= word_nx;
      o_addr_log_to_mem <= addr_nx;
      o_tx_data         <= tx_data_nx;
      o_tx_valid        <= (state_nx == SEND_HI)
                        || (state_nx == SEND_LO);
      o_read_log        <= (state_nx == FETCH)
                        || (state_nx == SEND_HI)
                        || (state_nx == SEND_LO);
      o_busy            <= (state_nx != IDLE);
      o_done            <= (state_nx == DONE);
      o_err             <= err_nx;
    end
  end

  // Abort wins over everything, including a same-cycle handshake.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_start && i_mem_full) state_nx = FETCH;
      FETCH:   if (lat_cnt == LAT_LAST) state_nx = SEND_HI;
      SEND_HI: if (i_tx_ready) state_nx = SEND_LO;
      SEND_LO: if (i_tx_ready) state_nx = last ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (i_abort && state != IDLE) state_nx = IDLE;
  end

  always_comb begin
    lat_cnt_nx = lat_cnt;
    word_nx    = word;
    addr_nx    = o_addr_log_to_mem;
    tx_data_nx = o_tx_data;
    err_nx     = (state == IDLE) && i_start && !i_mem_full;
    unique case (state)
      IDLE: begin
        if (state_nx == FETCH) begin
          addr_nx    = '0;
          lat_cnt_nx = '0;
        end
      end
      FETCH: begin
        lat_cnt_nx = lat_cnt + 4'd1;
        if (state_nx == SEND_HI) begin
          word_nx    = i_data_log_from_mem[15:0];
          tx_data_nx = i_data_log_from_mem[15:8];
        end
      end
      SEND_HI: begin
        if (state_nx == SEND_LO) tx_data_nx = word[7:0];
      end
      SEND_LO: begin
        if (state_nx == FETCH) begin
          addr_nx    = o_addr_log_to_mem + 1'b1;
          lat_cnt_nx = '0;
        end
      end
      default: ;
    endcase
  end

endmodule
